// File: rtl/hc595_driver.sv
// hc595_driver
// -----------------------------------------------------------------------------
// Upstream driver for a chain of cascaded 74HC595 shift-register/latch devices.
// A parallel word is accepted over a valid/ready handshake, shifted out MSB
// first on o_a with a generated shift clock, and then transferred to the
// chain's parallel outputs with a single latch-clock pulse. A clear request
// pulses the chain's shift-register reset and latches the resulting zeros.
// The chain output enable is a registered copy of the inverted enable request.
//
// Parameters
//   N_CHIPS : number of cascaded 74HC595 devices (word width W = 8*N_CHIPS)
//   CLK_DIV : system clocks per shift/latch clock half-period (1..255)
//
// Ports
//   i_clk            system clock, all logic on the rising edge
//   i_reset          synchronous active-high reset
//   i_data[W-1:0]    word to shift, sampled only on the handshake
//   i_valid          i_data is valid
//   o_ready          driver can accept a word (IDLE and no clear request)
//   i_clear          request a chain clear, sampled only in IDLE
//   i_oe_req         1 = drive the chain's parallel outputs
//   o_done           one-cycle pulse after a word is latched or a clear ends
//   o_a              serial data to the chain (pin A)
//   o_shiftclock     shift clock to the chain (pin SHIFTCLOCK)
//   o_sr_reset       active-low shift-register clear (pin RESET)
//   o_latchclock     storage-register clock (pin LATCHCLOCK)
//   o_outputenable   active-low output enable (pin OUTPUTENABLE)
// -----------------------------------------------------------------------------
module hc595_driver #(
  parameter int N_CHIPS = 1,
  parameter int CLK_DIV = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [8*N_CHIPS-1:0]   i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_clear,
  input  logic                   i_oe_req,
  output logic                   o_done,
  output logic                   o_a,
  output logic                   o_shiftclock,
  output logic                   o_sr_reset,
  output logic                   o_latchclock,
  output logic                   o_outputenable
);

  localparam int W     = 8 * N_CHIPS;
  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

  localparam logic [7:0]       PHASE_LAST = 8'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_TOP    = IDX_W'(W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LATCH_LO,
    S_LATCH_HI,
    S_CLR,
    S_CLR_LATCH
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [7:0]       r_phase;
  logic [7:0]       w_next_phase;
  logic [IDX_W-1:0] r_index;
  logic [IDX_W-1:0] w_next_index;
  logic [W-1:0]     r_shift;
  logic [W-1:0]     w_next_shift;
  logic             w_phase_end;
  logic             w_next_done;
  logic             w_next_a;
  logic             w_next_sck;
  logic             w_next_srr;
  logic             w_next_lck;

  logic r_done;
  logic r_a;
  logic r_sck;
  logic r_srr;
  logic r_lck;
  logic r_oe_n;

  // A clear request in IDLE blocks the handshake in the same cycle, so READY
  // has to see i_clear combinationally.
  assign o_ready = (r_state == S_IDLE) && !i_clear;

  // Next-state logic. Every non-IDLE state lasts CLK_DIV cycles, measured by
  // the phase counter; the transition happens on the last phase.
  always_comb begin
    w_next_state = r_state;
    w_next_index = r_index;
    w_next_shift = r_shift;
    w_next_done  = 1'b0;
    w_phase_end  = (r_phase == PHASE_LAST);

    case (r_state)
      S_IDLE: begin
        if (i_clear) begin
          w_next_state = S_CLR;
        end else if (i_valid) begin
          w_next_state = S_SHIFT_LO;
          w_next_shift = i_data;
          w_next_index = IDX_TOP;
        end
      end
      S_SHIFT_LO: begin
        if (w_phase_end) begin
          w_next_state = S_SHIFT_HI;
        end
      end
      S_SHIFT_HI: begin
        if (w_phase_end) begin
          if (r_index == '0) begin
            w_next_state = S_LATCH_LO;
          end else begin
            w_next_state = S_SHIFT_LO;
            w_next_index = r_index - 1'b1;
          end
        end
      end
      S_LATCH_LO: begin
        if (w_phase_end) begin
          w_next_state = S_LATCH_HI;
        end
      end
      S_LATCH_HI: begin
        if (w_phase_end) begin
          w_next_state = S_IDLE;
          w_next_done  = 1'b1;
        end
      end
      S_CLR: begin
        if (w_phase_end) begin
          w_next_state = S_CLR_LATCH;
        end
      end
      S_CLR_LATCH: begin
        if (w_phase_end) begin
          w_next_state = S_IDLE;
          w_next_done  = 1'b1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Phase counter restarts on every state change and is parked at 0 in IDLE.
  always_comb begin
    w_next_phase = 8'd0;
    if ((w_next_state == r_state) && (r_state != S_IDLE)) begin
      w_next_phase = r_phase + 8'd1;
    end
  end

  // Chain pin levels are decoded from the next state so that the registered
  // pins line up exactly with the state they belong to. A is driven from the
  // selected shift-register bit through both halves of a bit period.
  always_comb begin
    w_next_a   = 1'b0;
    w_next_sck = 1'b0;
    w_next_srr = 1'b1;
    w_next_lck = 1'b0;

    case (w_next_state)
      S_SHIFT_LO:  w_next_a   = w_next_shift[w_next_index];
      S_SHIFT_HI: begin
        w_next_a   = w_next_shift[w_next_index];
        w_next_sck = 1'b1;
      end
      S_LATCH_HI:  w_next_lck = 1'b1;
      S_CLR:       w_next_srr = 1'b0;
      S_CLR_LATCH: w_next_lck = 1'b1;
      default: begin
        w_next_a = 1'b0;
      end
    endcase
  end

  // State, datapath and registered chain pins. A mid-transfer reset returns
  // straight to IDLE without a latch pulse, so the chain keeps its old word.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_phase <= 8'd0;
      r_index <= '0;
      r_shift <= '0;
      r_done  <= 1'b0;
      r_a     <= 1'b0;
      r_sck   <= 1'b0;
      r_srr   <= 1'b1;
      r_lck   <= 1'b0;
      r_oe_n  <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_phase <= w_next_phase;
      r_index <= w_next_index;
      r_shift <= w_next_shift;
      r_done  <= w_next_done;
      r_a     <= w_next_a;
      r_sck   <= w_next_sck;
      r_srr   <= w_next_srr;
      r_lck   <= w_next_lck;
      r_oe_n  <= ~i_oe_req;
    end
  end

  assign o_done         = r_done;
  assign o_a            = r_a;
  assign o_shiftclock   = r_sck;
  assign o_sr_reset     = r_srr;
  assign o_latchclock   = r_lck;
  assign o_outputenable = r_oe_n;

endmodule

// File: tb/tb_hc595_driver.sv
// tb_hc595_driver
// -----------------------------------------------------------------------------
// Bench for hc595_driver. Two instances run side by side: dut0 with default
// parameters (one chip, CLK_DIV=2) and dut1 with two chips and CLK_DIV=1.
// A behavioural 74HC595 chain model listens to each driver's pins; stimulus
// tasks push the expected latched word and timing into a per-instance queue,
// and a negedge monitor pops an entry on every DONE pulse and compares.
// -----------------------------------------------------------------------------
module tb_hc595_driver;

  localparam int DIV0 = 2;
  localparam int W0   = 8;
  localparam int DIV1 = 1;
  localparam int W1   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        oeReq;
  logic [7:0]  data0;
  logic        valid0;
  logic        clear0;
  logic [15:0] data1;
  logic        valid1;
  logic        clear1;

  logic ready0, done0, a0, sck0, srr0, lck0, oe0;
  logic ready1, done1, a1, sck1, srr1, lck1, oe1;

  hc595_driver #(.N_CHIPS(1), .CLK_DIV(DIV0)) dut0 (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_data         (data0),
    .i_valid        (valid0),
    .o_ready        (ready0),
    .i_clear        (clear0),
    .i_oe_req       (oeReq),
    .o_done         (done0),
    .o_a            (a0),
    .o_shiftclock   (sck0),
    .o_sr_reset     (srr0),
    .o_latchclock   (lck0),
    .o_outputenable (oe0)
  );

  hc595_driver #(.N_CHIPS(2), .CLK_DIV(DIV1)) dut1 (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_data         (data1),
    .i_valid        (valid1),
    .o_ready        (ready1),
    .i_clear        (clear1),
    .i_oe_req       (oeReq),
    .o_done         (done1),
    .o_a            (a1),
    .o_shiftclock   (sck1),
    .o_sr_reset     (srr1),
    .o_latchclock   (lck1),
    .o_outputenable (oe1)
  );

  typedef struct {
    logic [15:0] storage;
    int          latency;
    int          srLow;
    string       name;
  } exp_t;

  exp_t sbq0[$];
  exp_t sbq1[$];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Chain model and per-transfer bookkeeping, one slot per instance.
  logic [15:0] sr[2];
  logic [15:0] store[2];
  logic        prevSck[2];
  logic        prevLck[2];
  logic        prevA[2];
  logic        aAtRise[2];
  bit          busy[2];
  bit          sawFall[2];
  int          stable[2];
  int          hiCnt[2];
  int          sinceFall[2];
  int          latchCnt[2];
  int          latchTotal[2];
  int          srLowCnt[2];
  int          readyLow[2];
  int          eventCycle[2];
  int          viol[2];

  always @(posedge clk) cycle <= cycle + 1;

  function automatic int expLatency(input int w, input int div);
    return (2 * w + 2) * div;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input int k, input logic [15:0] s, input int lat,
                         input int srl, input string nm);
    exp_t e;
    e.storage = s;
    e.latency = lat;
    e.srLow   = srl;
    e.name    = nm;
    if (k == 0) sbq0.push_back(e);
    else        sbq1.push_back(e);
  endtask

  task automatic popExp(input int k, output exp_t e, output bit ok);
    e.storage = '0;
    e.latency = 0;
    e.srLow   = 0;
    e.name    = "none";
    ok        = 1'b0;
    if (k == 0 && sbq0.size() > 0) begin
      e  = sbq0.pop_front();
      ok = 1'b1;
    end else if (k == 1 && sbq1.size() > 0) begin
      e  = sbq1.pop_front();
      ok = 1'b1;
    end
  endtask

  // One negedge sample of a driver's pins: advance the chain model, check
  // setup/hold and latch spacing, score a DONE pulse, then detect the start
  // of the next operation.
  task automatic monitorStep(input int k, input logic done, input logic ready,
                             input logic a, input logic sck, input logic srr,
                             input logic lck, input logic valid, input logic clear,
                             input logic rst, input int div, input int w);
    exp_t        e;
    bit          ok;
    logic [15:0] mask;
    mask = (w == 16) ? 16'hFFFF : 16'h00FF;

    if (a !== prevA[k]) stable[k] = 1;
    else                stable[k]++;

    if (!srr) begin
      sr[k] = '0;
      srLowCnt[k]++;
    end else if (sck && !prevSck[k]) begin
      sr[k] = {sr[k][14:0], a} & mask;
      if (stable[k] < div + 1) viol[k]++;
      aAtRise[k] = a;
      hiCnt[k]   = 0;
    end

    if (sck) begin
      hiCnt[k]++;
      if (a !== aAtRise[k]) viol[k]++;
    end

    if (!sck && prevSck[k]) begin
      if (hiCnt[k] != div) viol[k]++;
      sinceFall[k] = 0;
      sawFall[k]   = 1'b1;
    end else if (!sck) begin
      sinceFall[k]++;
    end

    if (lck && !prevLck[k]) begin
      store[k] = sr[k];
      latchCnt[k]++;
      latchTotal[k]++;
      if (sawFall[k] && sinceFall[k] != div) viol[k]++;
    end

    if (busy[k] && !ready) readyLow[k]++;

    if (done) begin
      popExp(k, e, ok);
      checkOutput($sformatf("done_expected_%0d", k), 32'(busy[k] && ok), 32'd1);
      if (busy[k] && ok) begin
        checkOutput({e.name, "_store"}, 32'(store[k]), 32'(e.storage));
        checkOutput({e.name, "_latency"}, 32'(cycle - eventCycle[k]), 32'(e.latency));
        checkOutput({e.name, "_ready_low"}, 32'(readyLow[k]), 32'(e.latency));
        checkOutput({e.name, "_latches"}, 32'(latchCnt[k]), 32'd1);
        checkOutput({e.name, "_sr_reset_low"}, 32'(srLowCnt[k]), 32'(e.srLow));
        checkOutput({e.name, "_timing"}, 32'(viol[k]), 32'd0);
      end
      busy[k] = 1'b0;
    end

    if (rst) begin
      busy[k] = 1'b0;
    end else if (!busy[k] && (clear || (valid && ready))) begin
      busy[k]       = 1'b1;
      eventCycle[k] = cycle + 1;
      readyLow[k]   = 0;
      latchCnt[k]   = 0;
      srLowCnt[k]   = 0;
      viol[k]       = 0;
      sawFall[k]    = 1'b0;
    end

    prevSck[k] = sck;
    prevLck[k] = lck;
    prevA[k]   = a;
  endtask

  always @(negedge clk) begin
    monitorStep(0, done0, ready0, a0, sck0, srr0, lck0, valid0, clear0, reset, DIV0, W0);
    monitorStep(1, done1, ready1, a1, sck1, srr1, lck1, valid1, clear1, reset, DIV1, W1);
  end

  // Present a word, wait (bounded) for the handshake, then scramble DATA to
  // show the captured word is not affected; VALID stays high when hold=1.
  task automatic applyStimulus(input int k, input logic [15:0] d, input bit hold);
    bit got;
    int n;
    @(posedge clk);
    #1;
    if (k == 0) begin data0 = d[7:0]; valid0 = 1'b1; end
    else        begin data1 = d;      valid1 = 1'b1; end
    got = 1'b0;
    n   = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      got = (k == 0) ? ready0 : ready1;
      n++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshake_timeout_%0d: actual ready=0, required ready=1", k);
    end
    @(posedge clk);
    #1;
    if (k == 0) begin data0 = ~d[7:0]; if (!hold) valid0 = 1'b0; end
    else        begin data1 = ~d;      if (!hold) valid1 = 1'b0; end
  endtask

  // Wait until the instance's queue has drained and it is idle; counts the
  // samples where dut0 drove OUTPUTENABLE active.
  task automatic waitDone(input int k, output int oeOn);
    int  n;
    bit  idle;
    oeOn = 0;
    n    = 0;
    idle = 1'b0;
    while (!idle && n < 400) begin
      @(negedge clk);
      if (!oe0) oeOn++;
      idle = (k == 0) ? (sbq0.size() == 0 && !busy[0]) : (sbq1.size() == 0 && !busy[1]);
      n++;
    end
    if (!idle) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout_%0d: actual pending, required drained", k);
    end
  endtask

  task automatic countUntilReady(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready0 && n < 200);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual running, required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int oeOn;
    int n;
    int latchBefore;

    for (int i = 0; i < 2; i++) begin
      sr[i] = '0; store[i] = '0; prevSck[i] = 1'b0; prevLck[i] = 1'b0;
      prevA[i] = 1'b0; aAtRise[i] = 1'b0; busy[i] = 1'b0; sawFall[i] = 1'b0;
      stable[i] = 0; hiCnt[i] = 0; sinceFall[i] = 0; latchCnt[i] = 0;
      latchTotal[i] = 0; srLowCnt[i] = 0; readyLow[i] = 0; eventCycle[i] = 0;
      viol[i] = 0;
    end
    reset  = 1'b1;
    oeReq  = 1'b0;
    data0  = '0;
    valid0 = 1'b0;
    clear0 = 1'b0;
    data1  = '0;
    valid1 = 1'b0;
    clear1 = 1'b0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    $display("[TB] reset values");
    checkOutput("rst_ready", ready0, 1);
    checkOutput("rst_done", done0, 0);
    checkOutput("rst_a", a0, 0);
    checkOutput("rst_sck", sck0, 0);
    checkOutput("rst_lck", lck0, 0);
    checkOutput("rst_srr", srr0, 1);
    checkOutput("rst_oe", oe0, 1);
    checkOutput("rst_ready_n2", ready1, 1);
    checkOutput("rst_srr_n2", srr1, 1);

    $display("[TB] word 8'hB1");
    pushExp(0, 16'h00B1, expLatency(W0, DIV0), 0, "word_b1");
    applyStimulus(0, 16'h00B1, 1'b0);
    waitDone(0, oeOn);

    $display("[TB] clear with simultaneous valid");
    pushExp(0, 16'h0000, 2 * DIV0, DIV0, "clear");
    pushExp(0, 16'h005A, expLatency(W0, DIV0), 0, "after_clear");
    @(posedge clk);
    #1;
    clear0 = 1'b1;
    valid0 = 1'b1;
    data0  = 8'h5A;
    @(negedge clk);
    checkOutput("clear_blocks_ready", ready0, 0);
    @(posedge clk);
    #1 clear0 = 1'b0;
    countUntilReady(n);
    checkOutput("clear_accept_sample", n, 2 * DIV0 + 1);
    @(posedge clk);
    #1;
    valid0 = 1'b0;
    data0  = 8'hC3;
    waitDone(0, oeOn);

    $display("[TB] output enable");
    pushExp(0, 16'h00A5, expLatency(W0, DIV0), 0, "word_a5");
    applyStimulus(0, 16'h00A5, 1'b0);
    waitDone(0, oeOn);
    checkOutput("oe_off_during_transfer", oeOn, 0);
    @(posedge clk);
    #1 oeReq = 1'b1;
    @(negedge clk);
    checkOutput("oe_enable_latency", oe0, 1);
    @(negedge clk);
    checkOutput("oe_enabled", oe0, 0);
    checkOutput("oe_chain_holds_a5", store[0], 16'h00A5);
    @(posedge clk);
    #1 oeReq = 1'b0;
    @(negedge clk);
    checkOutput("oe_disable_latency", oe0, 0);
    @(negedge clk);
    checkOutput("oe_disabled", oe0, 1);

    $display("[TB] back-to-back FF then 00");
    pushExp(0, 16'h00FF, expLatency(W0, DIV0), 0, "b2b_ff");
    pushExp(0, 16'h0000, expLatency(W0, DIV0), 0, "b2b_00");
    applyStimulus(0, 16'h00FF, 1'b1);
    data0 = 8'h00;
    countUntilReady(n);
    checkOutput("b2b_accept_sample", n, expLatency(W0, DIV0) + 1);
    @(posedge clk);
    #1;
    valid0 = 1'b0;
    data0  = 8'h77;
    waitDone(0, oeOn);

    $display("[TB] reset mid-transfer");
    pushExp(0, 16'h0081, expLatency(W0, DIV0), 0, "word_81");
    applyStimulus(0, 16'h0081, 1'b0);
    waitDone(0, oeOn);
    latchBefore = latchTotal[0];
    applyStimulus(0, 16'h003C, 1'b0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_ready", ready0, 1);
    checkOutput("midrst_done", done0, 0);
    checkOutput("midrst_a", a0, 0);
    checkOutput("midrst_sck", sck0, 0);
    checkOutput("midrst_lck", lck0, 0);
    checkOutput("midrst_srr", srr0, 1);
    repeat (50) @(negedge clk);
    checkOutput("midrst_no_latch", latchTotal[0], latchBefore);
    checkOutput("midrst_chain_keeps_81", store[0], 16'h0081);
    pushExp(0, 16'h003C, expLatency(W0, DIV0), 0, "word_3c");
    applyStimulus(0, 16'h003C, 1'b0);
    waitDone(0, oeOn);

    $display("[TB] two chips, CLK_DIV=1");
    pushExp(1, 16'h8001, expLatency(W1, DIV1), 0, "n2_8001");
    applyStimulus(1, 16'h8001, 1'b0);
    waitDone(1, oeOn);
    checkOutput("n2_chip1_qh", store[1][15], 1);
    checkOutput("n2_chip0_qa", store[1][0], 1);

    checkOutput("sb0_drained", sbq0.size(), 0);
    checkOutput("sb1_drained", sbq1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hc595_driver.md
# hc595_driver

Upstream driver for the 74HC595 shift-register/latch chain. Accepts a parallel word over a valid/ready handshake, serializes it MSB-first onto the chain's serial input with a generated SHIFTCLOCK, then pulses LATCHCLOCK to transfer the word to the parallel outputs. Also provides a chain-clear sequence and a registered output-enable control. Its outputs connect pin-for-pin to the A, SHIFTCLOCK, RESET, LATCHCLOCK and OUTPUTENABLE inputs of the chain.

## Interface
- N_CHIPS, 1: number of cascaded 74HC595 devices; word width W = 8*N_CHIPS.
- CLK_DIV, 2: system clocks per SHIFTCLOCK/LATCHCLOCK half-period; legal range 1..255.

- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- DATA  in  W  word to shift; sampled only on handshake.
- VALID  in  1  DATA valid.
- READY  out  1  driver can accept a word; READY = (state==IDLE) && !CLEAR.
- CLEAR  in  1  request chain clear; sampled only in IDLE.
- OE_REQ  in  1  1 = drive the chain's parallel outputs.
- DONE  out  1  one-cycle pulse when a word has been latched or a clear has completed.
- A  out  1  serial data to chain.
- SHIFTCLOCK  out  1  shift clock to chain; data shifts on rising edge.
- SR_RESET  out  1  active-low shift-register clear to chain RESET pin.
- LATCHCLOCK  out  1  storage-register clock; latches on rising edge.
- OUTPUTENABLE  out  1  active-low output enable to chain.

## Operation
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH_LO, LATCH_HI, CLR, CLR_LATCH.
- A phase counter counts 0..CLK_DIV-1 in each non-IDLE state; state advances when it reaches CLK_DIV-1.
- IDLE: handshake VALID && READY captures DATA into shift register, bit index = W-1, go to SHIFT_LO.
- CLEAR=1 in IDLE takes priority: READY is 0 that cycle, VALID is ignored, go to CLR.
- SHIFT_LO: SHIFTCLOCK=0, A = shift_reg[index]. Then SHIFT_HI.
- SHIFT_HI: SHIFTCLOCK=1, A held. Then, if index==0, go to LATCH_LO; else decrement index, go to SHIFT_LO.
- LATCH_LO: SHIFTCLOCK=0, LATCHCLOCK=0, A=0. Then LATCH_HI.
- LATCH_HI: LATCHCLOCK=1. Then IDLE with DONE=1 for that first IDLE cycle.
- CLR: SR_RESET=0. Then CLR_LATCH with SR_RESET=1, LATCHCLOCK=1. Then IDLE with DONE pulse. The result is all chain outputs at 0.
- Bit order: DATA[W-1] is shifted first and ends at Qh of the last chip. DATA[0] ends at Qa of the first chip.
- OUTPUTENABLE = ~OE_REQ, registered. It is independent of state and legal to change at any time.
- CLEAR outside IDLE is ignored and is not queued. VALID outside IDLE is not accepted.
- DATA changes after the handshake have no effect on the word being shifted.

## Timing
- Reset values: READY=1 (when CLEAR=0), DONE=0, A=0, SHIFTCLOCK=0, LATCHCLOCK=0, SR_RESET=1, OUTPUTENABLE=1 (outputs disabled); state IDLE; counters 0.
- All outputs except READY are registered and glitch-free.
- Word transfer: handshake at edge T0. READY is low for exactly (2W+2)*CLK_DIV cycles. DONE is high in the cycle READY returns.
- Word transfer, default parameters (W=8, CLK_DIV=2): 36 cycles.
- Clear transfer: READY is low for 2*CLK_DIV cycles.
- Data setup: A is stable CLK_DIV cycles before each SHIFTCLOCK rise and CLK_DIV cycles after it.
- Latch spacing: LATCHCLOCK rises CLK_DIV cycles after the last SHIFTCLOCK fall.
- Back-to-back: VALID held high in the DONE cycle is accepted that cycle, giving no idle gap beyond the DONE cycle.
- OE latency: one cycle from OE_REQ to OUTPUTENABLE.
- RESET mid-operation: next cycle is IDLE with all outputs at reset values. No LATCHCLOCK pulse is issued, so the chain's storage register keeps its previous word.
- CLK_DIV=1: SHIFTCLOCK toggles every cycle, giving a period of 2 CLK.

## Test plan
- Default params, DATA=8'b1011_0001, VALID one cycle → A sequence 1,0,1,1,0,0,0,1 sampled at 8 SHIFTCLOCK rises. Then one LATCHCLOCK pulse, and the chain model shows Qh..Qa=10110001. DONE exactly 36 cycles after handshake.
- OE_REQ=0 during a transfer, then 1 → OUTPUTENABLE=1 throughout, then 0 one cycle after OE_REQ rises. Chain outputs hold 8'hA5 from the prior transfer.
- Two words 8'hFF then 8'h00 with VALID held continuously → second handshake occurs in the DONE cycle, and the chain shows 00000000 after the second latch.
- CLEAR=1 and VALID=1 in the same IDLE cycle → VALID not accepted, SR_RESET low 2 cycles, LATCHCLOCK pulse, chain outputs 00000000, DONE after 4 cycles. Then VALID accepted.
- RESET asserted at cycle 10 of a 8'h3C transfer → all outputs at reset values next cycle, no LATCHCLOCK pulse, chain outputs keep the previous word 8'h81.
- N_CHIPS=2, CLK_DIV=1, DATA=16'h8001 → 16 shifts, READY low for 34 cycles. Chip1 Qh=1, chip0 Qa=1, all other outputs 0.
